// File: rtl/button_event_gen.sv
// N-channel debounced pushbutton event generator with optional hold-to-repeat.
// Events queue as per-channel pending bits and are granted lowest index first when ready.
module button_event_gen #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_EN       = 1,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [N_BUTTONS-1:0]                                  button_,
  input  logic                                                  ready,
  output logic [N_BUTTONS-1:0]                                  en,
  output logic                                                  en_any,
  output logic [((N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1)-1:0] en_idx,
  output logic                                                  overrun
);

  localparam int IW      = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
  localparam int CW      = $clog2(DEBOUNCE_CYCLES);
  localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW      = $clog2(REP_MAX);

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

  logic [N_BUTTONS-1:0] sync1, sync2, pressed;
  logic [N_BUTTONS-1:0] event_vec;
  logic [N_BUTTONS-1:0] pending, pending_nx;
  logic [N_BUTTONS-1:0] grant_vec;
  logic [IW-1:0]        grant_idx;
  logic                 found, grant_valid, overrun_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= button_;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [RW-1:0]  rep, rep_nx;
    logic           first, first_nx;
    logic           db_done, rep_done, ev;

    assign db_done  = (cnt == CW'(DEBOUNCE_CYCLES - 1));
    // first marks that the next repeat uses the longer initial hold interval
    assign rep_done = (rep == (first ? RW'(HOLD_CYCLES - 1) : RW'(REPEAT_CYCLES - 1)));

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
        rep   <= '0;
        first <= 1'b0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        rep   <= rep_nx;
        first <= first_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rep_nx   = rep;
      first_nx = first;
      case (state)
        IDLE: begin
          if (pressed[g]) begin
            state_nx = DB_PRESS;
            cnt_nx   = '0;
          end
        end
        DB_PRESS: begin
          if (!pressed[g]) begin
            state_nx = IDLE;
          end else if (db_done) begin
            state_nx = HELD;
            rep_nx   = '0;
            first_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        HELD: begin
          if (!pressed[g]) begin
            state_nx = DB_RELEASE;
            cnt_nx   = '0;
          end else if (REPEAT_EN != 0) begin
            if (rep_done) begin
              rep_nx   = '0;
              first_nx = 1'b0;
            end else begin
              rep_nx = rep + 1'b1;
            end
          end
        end
        DB_RELEASE: begin
          if (pressed[g]) begin
            state_nx = HELD;
            rep_nx   = '0;
            first_nx = 1'b1;
          end else if (db_done) begin
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    always_comb begin
      ev = 1'b0;
      case (state)
        DB_PRESS: ev = pressed[g] && db_done;
        HELD:     ev = pressed[g] && (REPEAT_EN != 0) && rep_done;
        default:  ev = 1'b0;
      endcase
    end

    assign event_vec[g] = ev;
  end

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      if (pending[i] && !found) begin
        found     = 1'b1;
        grant_idx = IW'(i);
      end
    end
    grant_valid = ready && found;
    grant_vec   = '0;
    if (grant_valid) grant_vec[grant_idx] = 1'b1;
    // a new event on the channel being granted re-arms its pending bit without overrun
    pending_nx = (pending & ~grant_vec) | event_vec;
    overrun_nx = |(event_vec & pending & ~grant_vec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      en      <= '0;
      en_any  <= 1'b0;
      en_idx  <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= pending_nx;
      en      <= grant_vec;
      en_any  <= grant_valid;
      en_idx  <= grant_valid ? grant_idx : '0;
      overrun <= overrun_nx;
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen: expected grants/overruns are queued with their
// cycle numbers when stimulus is applied and compared cycle by cycle against the outputs.
module tb_button_event_gen;

  localparam int N = 4;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] button_, bn;
  logic       ready, rn;
  logic [3:0] en, en_n;
  logic       en_any, en_any_n;
  logic [1:0] en_idx, en_idx_n;
  logic       overrun, overrun_n;

  button_event_gen #(
    .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut_r (
    .clk(clk), .reset(reset), .button_(button_), .ready(ready),
    .en(en), .en_any(en_any), .en_idx(en_idx), .overrun(overrun)
  );

  button_event_gen #(
    .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut_n (
    .clk(clk), .reset(reset), .button_(bn), .ready(rn),
    .en(en_n), .en_any(en_any_n), .en_idx(en_idx_n), .overrun(overrun_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] v;
  } exp_t;

  exp_t q_r[$];
  exp_t q_n[$];
  int   q_ov[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic expect_r(input int c, input logic [3:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    q_r.push_back(e);
  endtask

  task automatic expect_n(input int c, input logic [3:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    q_n.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q_r.size() > 0 && q_r[0].c < cyc) begin
      check("en_missed", 32'(cyc), 32'(q_r[0].c));
      void'(q_r.pop_front());
    end
    if (q_r.size() > 0 && q_r[0].c == cyc) begin
      exp_t e;
      e = q_r.pop_front();
      check("en", 32'(en), 32'(e.v));
      check("en_any", 32'(en_any), 1);
      check("en_idx", 32'(en_idx), 32'(idx_of(e.v)));
    end else begin
      check("en_idle", 32'(en), 0);
      check("en_any_idle", 32'(en_any), 0);
      check("en_idx_idle", 32'(en_idx), 0);
    end
    if (q_ov.size() > 0 && q_ov[0] < cyc) begin
      check("overrun_missed", 32'(cyc), 32'(q_ov[0]));
      void'(q_ov.pop_front());
    end
    if (q_ov.size() > 0 && q_ov[0] == cyc) begin
      void'(q_ov.pop_front());
      check("overrun", 32'(overrun), 1);
    end else begin
      check("overrun_idle", 32'(overrun), 0);
    end
  end

  always @(negedge clk) begin
    if (q_n.size() > 0 && q_n[0].c < cyc) begin
      check("norep_en_missed", 32'(cyc), 32'(q_n[0].c));
      void'(q_n.pop_front());
    end
    if (q_n.size() > 0 && q_n[0].c == cyc) begin
      exp_t e;
      e = q_n.pop_front();
      check("norep_en", 32'(en_n), 32'(e.v));
      check("norep_en_any", 32'(en_any_n), 1);
      check("norep_en_idx", 32'(en_idx_n), 32'(idx_of(e.v)));
    end else begin
      check("norep_en_idle", 32'(en_n), 0);
      check("norep_en_any_idle", 32'(en_any_n), 0);
      check("norep_overrun", 32'(overrun_n), 0);
    end
  end

  initial begin
    int e0;
    int budget;
    reset   = 1'b1;
    button_ = '1;
    bn      = '1;
    ready   = 1'b1;
    rn      = 1'b1;

    // reset, then a quiet interval with no events
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);

    // single press on channel 1 of both instances, held shorter than the hold interval
    e0 = cyc + 1;
    button_[1] = 1'b0;
    bn[1]      = 1'b0;
    expect_r(e0 + D + 3, 4'b0010);
    expect_n(e0 + D + 3, 4'b0010);
    repeat (15) @(negedge clk);
    button_[1] = 1'b1;
    bn[1]      = 1'b1;
    repeat (30) @(negedge clk);

    // glitch shorter than the debounce window
    button_[0] = 1'b0;
    repeat (3) @(negedge clk);
    button_[0] = 1'b1;
    repeat (20) @(negedge clk);

    // bounce then steady press
    for (int k = 0; k < 5; k++) begin
      button_[0] = 1'b0;
      @(negedge clk);
      button_[0] = 1'b1;
      @(negedge clk);
    end
    e0 = cyc + 1;
    button_[0] = 1'b0;
    expect_r(e0 + D + 3, 4'b0001);
    repeat (10) @(negedge clk);
    button_[0] = 1'b1;
    repeat (20) @(negedge clk);

    // hold-to-repeat on channel 2
    e0 = cyc + 1;
    button_[2] = 1'b0;
    expect_r(e0 + D + 3, 4'b0100);
    for (int k = 0; k < 5; k++) expect_r(e0 + D + 3 + H + k * R, 4'b0100);
    repeat (60) @(negedge clk);
    button_[2] = 1'b1;
    repeat (40) @(negedge clk);

    // long hold with repeat disabled gives a single event
    e0 = cyc + 1;
    bn[1] = 1'b0;
    expect_n(e0 + D + 3, 4'b0010);
    repeat (60) @(negedge clk);
    bn[1] = 1'b1;
    repeat (30) @(negedge clk);

    // events accumulate while not ready, then drain in index order
    ready      = 1'b0;
    button_[3] = 1'b0;
    button_[1] = 1'b0;
    repeat (10) @(negedge clk);
    button_ = '1;
    repeat (20) @(negedge clk);
    ready = 1'b1;
    expect_r(cyc + 1, 4'b0010);
    expect_r(cyc + 2, 4'b1000);
    repeat (10) @(negedge clk);

    // merged repeat while not ready, then reset mid-hold
    ready = 1'b0;
    e0 = cyc + 1;
    button_[0] = 1'b0;
    q_ov.push_back(e0 + D + 2 + H);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ready = 1'b1;
    expect_r(cyc + D + 4, 4'b0001);
    repeat (12) @(negedge clk);
    button_[0] = 1'b1;
    repeat (30) @(negedge clk);

    budget = 200;
    while ((q_r.size() + q_n.size() + q_ov.size()) > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("queues_drained", 32'(q_r.size() + q_n.size() + q_ov.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
